// File: rtl/pipe_reg_elastic_pkg.sv
// Shared types for the elastic register chain.
// Stage state encoding and occupancy-width helper.
package pipe_reg_elastic_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_st_t;

  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_elastic_skid.sv
// One elastic stage: main register drives the output,
// skid register catches the beat accepted while stalled.
module pipe_stage_skid
  import pipe_reg_elastic_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  stage_st_t        r_state;
  stage_st_t        w_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_next       = ST_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_next    = ST_TWO;
          w_ld_skid = 1'b1;
        end else if (w_out_fire) begin
          w_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_next         = ST_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= RESET_DATA;
      r_skid  <= RESET_DATA;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
      if (w_ld_main_in) begin
        r_main <= in_data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Chain of DEPTH elastic stages with flush and
// a registered count of words in flight.
module pipe_reg_elastic
  import pipe_reg_elastic_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [occ_w(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  logic [WIDTH-1:0] w_data  [DEPTH+1];
  logic             w_valid [DEPTH+1];
  logic             w_ready [DEPTH+1];
  logic [OCC_W-1:0] r_occ;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_data[0]      = in_data;
  assign w_valid[0]     = in_valid;
  assign in_ready       = w_ready[0];
  assign w_ready[DEPTH] = out_ready;
  assign out_data       = w_data[DEPTH];
  assign out_valid      = w_valid[DEPTH];
  assign occupancy      = r_occ;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage_skid #(
      .WIDTH     (WIDTH),
      .RESET_DATA(RESET_DATA)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_data  (w_data[i]),
      .in_valid (w_valid[i]),
      .in_ready (w_ready[i]),
      .out_data (w_data[i+1]),
      .out_valid(w_valid[i+1]),
      .out_ready(w_ready[i+1])
    );
  end

  assign w_in_fire  = in_valid && w_ready[0];
  assign w_out_fire = w_valid[DEPTH] && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: vector table, directed
// flush/reset sequences and a scoreboarded random run.
module tb_pipe_reg_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: DEPTH=2, WIDTH=32
  logic        ra, fla, iva, ora;
  logic [31:0] da;
  logic        ira, ova;
  logic [31:0] oda;
  logic [2:0]  occa;

  // DUT B: DEPTH=3, WIDTH=8
  logic        rb, flb, ivb, orb;
  logic [7:0]  db;
  logic        irb, ovb;
  logic [7:0]  odb;
  logic [2:0]  occb;

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(2), .RESET_DATA(32'h0)) u_a (
    .clk(clk), .reset(ra), .flush(fla),
    .in_data(da), .in_valid(iva), .in_ready(ira),
    .out_data(oda), .out_valid(ova), .out_ready(ora),
    .occupancy(occa)
  );

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(3), .RESET_DATA(8'hA5)) u_b (
    .clk(clk), .reset(rb), .flush(flb),
    .in_data(db), .in_valid(ivb), .in_ready(irb),
    .out_data(odb), .out_valid(ovb), .out_ready(orb),
    .occupancy(occb)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic        orr;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic        cd;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t tv [15];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  int         seen;

  initial begin
    // rst iv d orr | ir ov od cd occ
    tv[0]  = '{1, 1, 32'h11, 0, 1, 0, 32'h0,  1, 0};
    tv[1]  = '{0, 0, 32'h0,  0, 1, 0, 32'h0,  1, 0};
    tv[2]  = '{0, 1, 32'hA0, 0, 1, 0, 32'h0,  1, 0};
    tv[3]  = '{0, 1, 32'hA1, 0, 1, 0, 32'h0,  0, 1};
    tv[4]  = '{0, 1, 32'hA2, 0, 1, 1, 32'hA0, 1, 2};
    tv[5]  = '{0, 1, 32'hA3, 0, 1, 1, 32'hA0, 1, 3};
    tv[6]  = '{0, 1, 32'hA4, 0, 0, 1, 32'hA0, 1, 4};
    tv[7]  = '{0, 1, 32'hA5, 0, 0, 1, 32'hA0, 1, 4};
    tv[8]  = '{0, 1, 32'hA4, 1, 0, 1, 32'hA0, 1, 4};
    tv[9]  = '{0, 1, 32'hA4, 1, 0, 1, 32'hA1, 1, 3};
    tv[10] = '{0, 1, 32'hA4, 1, 1, 1, 32'hA2, 1, 2};
    tv[11] = '{0, 1, 32'hA5, 1, 1, 1, 32'hA3, 1, 2};
    tv[12] = '{0, 0, 32'h0,  1, 1, 1, 32'hA4, 1, 2};
    tv[13] = '{0, 0, 32'h0,  1, 1, 1, 32'hA5, 1, 1};
    tv[14] = '{0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 0};

    ra = 1; fla = 0; iva = 1; da = 32'h11; ora = 0;
    rb = 1; flb = 0; ivb = 0; db = 8'h0; orb = 0;
    step();

    for (int i = 0; i < 15; i++) begin
      ra  = tv[i].rst;
      iva = tv[i].iv;
      da  = tv[i].d;
      ora = tv[i].orr;
      chk($sformatf("v%0d_in_ready", i), 32'(ira), 32'(tv[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(ova), 32'(tv[i].e_ov));
      chk($sformatf("v%0d_occ", i), 32'(occa), 32'(tv[i].e_occ));
      if (tv[i].cd)
        chk($sformatf("v%0d_out_data", i), oda, tv[i].e_od);
      step();
    end

    // back-to-back stream 1..10
    ora = 1;
    for (int t = 0; t < 13; t++) begin
      iva = (t < 10);
      da  = 32'(t + 1);
      chk($sformatf("st%0d_in_ready", t), 32'(ira), 32'd1);
      chk($sformatf("st%0d_out_valid", t), 32'(ova),
          32'(t >= 2 && t < 12));
      if (t >= 2 && t < 12)
        chk($sformatf("st%0d_out_data", t), oda, 32'(t - 1));
      chk($sformatf("st%0d_occ", t), 32'(occa),
          (t == 0 || t == 12) ? 32'd0 :
          (t == 1 || t == 11) ? 32'd1 : 32'd2);
      step();
    end

    // flush with 3 words held; the 0x55 beat is lost
    ora = 0; iva = 1;
    for (int w = 0; w < 3; w++) begin
      da = 32'hB1 + 32'(w);
      step();
    end
    iva = 0;
    chk("fl_occ_before", 32'(occa), 32'd3);
    fla = 1; iva = 1; da = 32'h55; ora = 1;
    chk("fl_in_ready", 32'(ira), 32'd1);
    step();
    fla = 0; da = 32'h66;
    chk("fl_out_valid", 32'(ova), 32'd0);
    chk("fl_occ", 32'(occa), 32'd0);
    step();
    iva = 0;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      if (ova) begin
        seen++;
        chk("fl_word", oda, 32'h66);
      end
      step();
    end
    chk("fl_word_count", 32'(seen), 32'd1);

    // reset mid-stream overrides flush
    ora = 0; iva = 1;
    for (int w = 0; w < 4; w++) begin
      da = 32'hC0 + 32'(w);
      step();
    end
    chk("rm_occ_full", 32'(occa), 32'd4);
    chk("rm_in_ready_full", 32'(ira), 32'd0);
    ra = 1; fla = 1; ora = 1; iva = 1; da = 32'hDD;
    step();
    ra = 0; fla = 0; iva = 0;
    chk("rm_out_valid", 32'(ova), 32'd0);
    chk("rm_out_data", oda, 32'h0);
    chk("rm_occ", 32'(occa), 32'd0);
    chk("rm_in_ready", 32'(ira), 32'd1);

    // random stress on DUT B
    rb = 0;
    chk("b_rst_data", 32'(odb), 32'hA5);
    chk("b_rst_valid", 32'(ovb), 32'd0);
    for (int c = 0; c < 2000; c++) begin
      ivb = ($urandom_range(0, 3) != 0);
      db  = 8'($urandom);
      orb = (c % 400 < 200) ? ($urandom_range(0, 3) != 0)
                            : ($urandom_range(0, 3) == 0);
      chk("b_occ", 32'(occb), 32'(q.size()));
      if (occb > 3'd6) chk("b_occ_max", 32'(occb), 32'd6);
      if (ovb && orb) begin
        if (q.size() == 0) chk("b_spurious", 32'(ovb), 32'd0);
        else chk("b_data", 32'(odb), 32'(q.pop_front()));
      end
      if (ivb && irb) q.push_back(db);
      step();
    end
    ivb = 0; orb = 1;
    for (int c = 0; c < 20; c++) begin
      if (ovb) begin
        if (q.size() == 0) chk("b_drain_extra", 32'(ovb), 32'd0);
        else chk("b_drain_data", 32'(odb), 32'(q.pop_front()));
      end
      step();
    end
    chk("b_drain_left", 32'(q.size()), 32'd0);
    chk("b_drain_occ", 32'(occb), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor to the single-word datapath holding registers (A/B/ALUOut style) in the multicycle CPU.
- Implements a chain of DEPTH elastic register stages carrying a WIDTH-bit word with valid/ready handshaking, synchronous flush and occupancy reporting.
- Lets the datapath stall or pipeline operand paths without losing or duplicating words.
- Sits between producer and consumer units, e.g. register file read port and ALU operand mux.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 2, number of elastic stages (>=1); each stage holds up to 2 words.
- RESET_DATA, 0, value loaded into all data registers on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held words.
- in_data  input  WIDTH  upstream word.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  WIDTH  word at head of chain.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- occupancy  output  $clog2(2*DEPTH+1)  number of words currently held.

Behaviour:
- Transfer rules: a beat transfers on a port when valid && ready at a posedge. in_ready never depends combinationally on out_ready; every ready is a registered function of stage state.
- Each stage has a main register (drives the stage output) and a skid register, with three states:
  - EMPTY: main invalid. Incoming beat -> ONE, main<=in.
  - ONE: main valid, skid empty.
    - Input accepted and output taken -> ONE, main<=in.
    - Input accepted and output not taken -> TWO, skid<=in.
    - No input and output taken -> EMPTY.
    - Otherwise hold.
  - TWO: main and skid valid; stage ready=0. Output taken -> ONE, main<=skid. Otherwise hold.
- Stage ready is high when state != TWO.
- Chaining: stage i output feeds stage i+1 input. in_* connects to stage 0; out_* connects to stage DEPTH-1.
- Latency: a word accepted at edge k is on out_data with out_valid=1 after edge k+DEPTH-1, i.e. it is visible in the cycle following edge k+DEPTH-1. Each stage adds one register.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Capacity: 2*DEPTH words. in_ready=0 only when stage 0 is in TWO.
- Ordering: strict FIFO. No word is dropped or duplicated except by flush or reset.
- occupancy: registered count.
  - +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
  - Never exceeds 2*DEPTH and never underflows.
- flush: at the next edge, all stages go to EMPTY and occupancy becomes 0. Data registers are not cleared.
  - flush has priority: an in_valid beat or out_ready in the same cycle is ignored and the input beat is lost. The upstream producer must treat a flush cycle as non-accepting.
  - in_ready is still reported normally during the flush cycle.
- reset: overrides flush.
  - All stages go to EMPTY, data registers <= RESET_DATA, occupancy=0.
  - After reset: out_valid=0, out_data=RESET_DATA, in_ready=1.
  - Reset mid-stream discards all words; there is no partial drain.
- out_data is driven from main-register state only; it is never combinational from in_data.
- out_data while out_valid=0 is the last held value and is don't-care for the consumer.

Decomposition:
- Shared package: stage state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and a function computing the occupancy width from DEPTH.
- One sub-module, pipe_stage_skid: one elastic stage with ports clk, reset, flush, in/out handshakes and data, plus parameter WIDTH/RESET_DATA.
- The top level instantiates DEPTH copies in a generate loop and holds the occupancy counter.

Test Plan:
- Reset value: DEPTH=2, WIDTH=32, assert reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, occupancy=0, in_ready=1 throughout and one cycle after release.
- Streaming: out_ready=1, send 1..10 back-to-back -> first word appears one cycle after edge k+1 (DEPTH=2), then 1..10 on consecutive cycles, in_ready constantly 1, occupancy steady at 2 during the stream.
- Backpressure: out_ready=0, in_valid=1 with words 0xA0..0xA7 -> exactly 4 accepted (0xA0-0xA3), in_ready=0 after the 4th, occupancy=4. Then out_ready=1 -> 0xA0,0xA1,0xA2,0xA3,0xA4... in order with no gaps or repeats.
- Flush: 3 words held, flush=1 with in_valid=1 (word 0x55) -> next cycle out_valid=0, occupancy=0. 0x55 never emerges and the next sent word 0x66 emerges alone.
- Reset mid-operation: fill to occupancy 4, assert reset with flush=1 and out_ready=1 -> one cycle later all valids 0, out_data=RESET_DATA, occupancy=0.
- Random stress: DEPTH=3, WIDTH=8, random in_valid/out_ready for 2000 cycles against a scoreboard queue -> output sequence identical to accepted sequence, occupancy equals queue length every cycle, occupancy never >6.
